// File: rtl/scrypt_blockmix_r1_pkg.sv
// scrypt_pkg: shared types and helpers for the scrypt BlockMix (r=1) core.
//   word_t      - 32-bit Salsa word
//   block512_t  - 16 Salsa words; index k is word k of a 64-byte half-block
//   state_t     - BlockMix controller states
//   quarter_round, bswap32, to_words, from_words - Salsa20 helpers
package scrypt_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] block512_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
  } qr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SALSA1 = 2'd1,
    SALSA2 = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Salsa rounds per invocation (even: column/row pairs)
  localparam int ROUNDS = 8;

  // Quarter-round rotation amounts, in the order they are applied
  localparam int ROT_B = 7;
  localparam int ROT_C = 9;
  localparam int ROT_D = 13;
  localparam int ROT_A = 18;

  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // b ^= (a+d)<<<7; c ^= (b+a)<<<9; d ^= (c+b)<<<13; a ^= (d+c)<<<18
  function automatic qr_t quarter_round(input word_t a, input word_t b,
                                        input word_t c, input word_t d);
    qr_t q;
    q.b = b ^ rotl(a + d, ROT_B);
    q.c = c ^ rotl(q.b + a, ROT_C);
    q.d = d ^ rotl(q.c + q.b, ROT_D);
    q.a = a ^ rotl(q.d + q.c, ROT_A);
    return q;
  endfunction

  function automatic word_t bswap32(input word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Byte string (byte 0 in the top byte) to little-endian words
  function automatic block512_t to_words(input logic [511:0] data);
    block512_t w;
    for (int k = 0; k < 16; k++) begin
      w[k] = bswap32(data[511 - 32*k -: 32]);
    end
    return w;
  endfunction

  // Little-endian words back to a byte string (byte 0 in the top byte)
  function automatic logic [511:0] from_words(input block512_t w);
    logic [511:0] data;
    data = '0;
    for (int k = 0; k < 16; k++) begin
      data[511 - 32*k -: 32] = bswap32(w[k]);
    end
    return data;
  endfunction

endpackage

// File: rtl/scrypt_blockmix_r1_if.sv
// scrypt_blockmix_r1_if: request/result bundle between the ROMix controller
// and the BlockMix core.
//   init  - level start request (controller -> core)
//   in    - B0||B1 byte string (controller -> core)
//   out   - Y0||Y1 byte string (core -> controller)
//   valid - result valid level (core -> controller)
interface scrypt_blockmix_r1_if;
  logic          init;
  logic [1023:0] in;
  logic [1023:0] out;
  logic          valid;

  modport master (output init, output in, input out, input valid);
  modport slave  (input init, input in, output out, output valid);
endinterface

// File: rtl/scrypt_blockmix_r1_salsa_round.sv
// salsa_round: one combinational Salsa20 double-round half.
//   state      - current 16-word Salsa state
//   row_sel    - 0: column round, 1: row round
//   next_state - state after the four quarter-rounds of this round
module salsa_round
  import scrypt_pkg::*;
(
  input  block512_t state,
  input  logic      row_sel,
  output block512_t next_state
);

  // Quarter-round word groups, listed as (a, b, c, d)
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd5,  4'd9,  4'd13, 4'd1},
    '{4'd10, 4'd14, 4'd2,  4'd6},
    '{4'd15, 4'd3,  4'd7,  4'd11}
  };
  localparam logic [3:0] ROW_IDX [4][4] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3},
    '{4'd5,  4'd6,  4'd7,  4'd4},
    '{4'd10, 4'd11, 4'd8,  4'd9},
    '{4'd15, 4'd12, 4'd13, 4'd14}
  };

  qr_t        q_s;
  logic [3:0] ia_s, ib_s, ic_s, id_s;

  // Four independent quarter-rounds; groups touch disjoint words
  always_comb begin
    next_state = state;
    q_s        = '0;
    ia_s       = 4'd0;
    ib_s       = 4'd0;
    ic_s       = 4'd0;
    id_s       = 4'd0;
    for (int g = 0; g < 4; g++) begin
      if (row_sel) begin
        ia_s = ROW_IDX[g][0];
        ib_s = ROW_IDX[g][1];
        ic_s = ROW_IDX[g][2];
        id_s = ROW_IDX[g][3];
      end else begin
        ia_s = COL_IDX[g][0];
        ib_s = COL_IDX[g][1];
        ic_s = COL_IDX[g][2];
        id_s = COL_IDX[g][3];
      end
      q_s = quarter_round(state[ia_s], state[ib_s], state[ic_s], state[id_s]);
      next_state[ia_s] = q_s.a;
      next_state[ib_s] = q_s.b;
      next_state[ic_s] = q_s.c;
      next_state[id_s] = q_s.d;
    end
  end

endmodule

// File: rtl/scrypt_blockmix_r1.sv
// scrypt_blockmix_r1: iterative scrypt BlockMix with r=1.
// One shared Salsa round per clock; two Salsa20/8 invocations per block,
// so a start sampled at edge 0 produces valid after edge 16.
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - slave side of scrypt_blockmix_r1_if (init, in, out, valid)
module scrypt_blockmix_r1 #(
  parameter int ROUNDS = 8
) (
  input logic                  clk,
  input logic                  reset,
  scrypt_blockmix_r1_if.slave  bus
);

  import scrypt_pkg::*;

  localparam logic [2:0] LAST_RC = 3'(ROUNDS - 1);

  state_t        state_r, state_nxt_s;
  logic [2:0]    rc_r, rc_nxt_s;
  block512_t     x_r, x_nxt_s;      // working Salsa state
  block512_t     f_r, f_nxt_s;      // feed-forward (Salsa input)
  block512_t     b1_r, b1_nxt_s;    // captured B1, reused for X1
  block512_t     y0_r, y0_nxt_s;
  logic [1023:0] out_r, out_nxt_s;
  logic          valid_r;

  block512_t     round_s;
  block512_t     ff_s;
  block512_t     in_b0_s, in_b1_s;
  logic          last_s;

  assign in_b0_s = to_words(bus.in[1023:512]);
  assign in_b1_s = to_words(bus.in[511:0]);
  assign last_s  = (rc_r == LAST_RC);

  salsa_round u_round (
    .state      (x_r),
    .row_sel    (rc_r[0]),
    .next_state (round_s)
  );

  // Salsa output: final round result plus the invocation's input
  always_comb begin
    ff_s = '0;
    for (int k = 0; k < 16; k++) begin
      ff_s[k] = round_s[k] + f_r[k];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; init is only looked at in IDLE and DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.init) state_nxt_s = SALSA1;
        else          state_nxt_s = IDLE;
      end
      SALSA1: begin
        if (last_s) state_nxt_s = SALSA2;
        else        state_nxt_s = SALSA1;
      end
      SALSA2: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = SALSA2;
      end
      DONE: begin
        if (bus.init) state_nxt_s = DONE;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values per state
  always_comb begin
    rc_nxt_s  = rc_r;
    x_nxt_s   = x_r;
    f_nxt_s   = f_r;
    b1_nxt_s  = b1_r;
    y0_nxt_s  = y0_r;
    out_nxt_s = out_r;
    case (state_r)
      IDLE: begin
        if (bus.init) begin
          b1_nxt_s = in_b1_s;
          x_nxt_s  = in_b1_s ^ in_b0_s;
          f_nxt_s  = in_b1_s ^ in_b0_s;
          rc_nxt_s = 3'd0;
        end else begin
          rc_nxt_s = rc_r;
        end
      end
      SALSA1: begin
        if (last_s) begin
          y0_nxt_s = ff_s;
          x_nxt_s  = ff_s ^ b1_r;
          f_nxt_s  = ff_s ^ b1_r;
          rc_nxt_s = 3'd0;
        end else begin
          x_nxt_s  = round_s;
          rc_nxt_s = rc_r + 3'd1;
        end
      end
      SALSA2: begin
        if (last_s) begin
          out_nxt_s = {from_words(y0_r), from_words(ff_s)};
          rc_nxt_s  = 3'd0;
        end else begin
          x_nxt_s  = round_s;
          rc_nxt_s = rc_r + 3'd1;
        end
      end
      DONE: begin
        rc_nxt_s = rc_r;
      end
      default: begin
        rc_nxt_s = 3'd0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rc_r    <= 3'd0;
      x_r     <= '0;
      f_r     <= '0;
      b1_r    <= '0;
      y0_r    <= '0;
      out_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      rc_r    <= rc_nxt_s;
      x_r     <= x_nxt_s;
      f_r     <= f_nxt_s;
      b1_r    <= b1_nxt_s;
      y0_r    <= y0_nxt_s;
      out_r   <= out_nxt_s;
      valid_r <= (state_nxt_s == DONE);
    end
  end

  assign bus.out   = out_r;
  assign bus.valid = valid_r;

endmodule

// File: tb/tb_scrypt_blockmix_r1.sv
// tb_scrypt_blockmix_r1: directed bench for scrypt_blockmix_r1 using the
// RFC 7914 BlockMix r=1 vector and the all-zero block.
module tb_scrypt_blockmix_r1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scrypt_blockmix_r1_if bus_if ();

  scrypt_blockmix_r1 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  localparam logic [1023:0] RFC_IN = {
    128'hf7ce0b653d2d72a4108cf5abe912ffdd, 128'h777616dbbb27a70e8204f3ae2d0f6fad,
    128'h89f68f4811d1e87bcc3bd7400a9ffd29, 128'h094f0184639574f39ae5a1315217bcd7,
    128'h894991447213bb226c25b54da86370fb, 128'hcd984380374666bb8ffcb5bf40c254b0,
    128'h67d27c51ce4ad5fed829c90b505a571b, 128'h7f4d1cad6a523cda770e67bceaaf7e89};
  localparam logic [511:0] RFC_Y0 = {
    128'ha41f859c6608cc993b81cacb020cef05, 128'h044b2181a2fd337dfd7b1c6396682f29,
    128'hb4393168e3c9e6bcfe6bc5b7a06d96ba, 128'he424cc102c91745c24ad673dc7618f81};
  localparam logic [511:0] RFC_Y1 = {
    128'h20edc975323881a80540f64c162dcd3c, 128'h21077cfe5f8d5fe2b1a4168f953678b7,
    128'h7d3b3d803b60e4ab920996e59b4d53b6, 128'h5d2a225877d5edf5842cb9f14eefe425};
  localparam logic [1023:0] RFC_OUT = {RFC_Y0, RFC_Y1};
  localparam logic [1023:0] ZERO    = 1024'd0;
  localparam int LIMIT = 40;

  int checks   = 0;
  int failures = 0;

  // Consumes the sampling edge, then counts edges until valid (bounded)
  task automatic run_to_valid(output int lat);
    lat = 0;
    @(posedge clk);
    while (lat < LIMIT) begin
      @(negedge clk);
      if (bus_if.valid === 1'b1) break;
      @(posedge clk);
      lat++;
    end
  endtask

  // Drop init long enough for the core to return to IDLE
  task automatic go_idle();
    @(negedge clk);
    bus_if.init = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1;
    bus_if.init = 1'b1;
    bus_if.in = RFC_IN;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus_if.valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid got=%b exp=0", bus_if.valid);
      end
      checks++;
      if (bus_if.out !== ZERO) begin
        failures++;
        $display("FAIL reset_out got=%h exp=0", bus_if.out);
      end
    end
    reset = 1'b0;
    run_to_valid(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL reset_latency got=%0d exp=16", lat);
    end
    checks++;
    if (bus_if.out !== RFC_OUT) begin
      failures++;
      $display("FAIL reset_first_out got=%h exp=%h", bus_if.out[1023:896], RFC_OUT[1023:896]);
    end
  endtask

  task automatic test_zero();
    int lat;
    go_idle();
    bus_if.in = ZERO;
    bus_if.init = 1'b1;
    run_to_valid(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL zero_latency got=%0d exp=16", lat);
    end
    checks++;
    if (bus_if.out !== ZERO) begin
      failures++;
      $display("FAIL zero_out got=%h exp=0", bus_if.out);
    end
  endtask

  task automatic test_rfc();
    int lat;
    go_idle();
    bus_if.in = RFC_IN;
    bus_if.init = 1'b1;
    run_to_valid(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL rfc_latency got=%0d exp=16", lat);
    end
    checks++;
    if (bus_if.out[1023:512] !== RFC_Y0) begin
      failures++;
      $display("FAIL rfc_y0 got=%h exp=%h", bus_if.out[1023:512], RFC_Y0);
    end
    checks++;
    if (bus_if.out[511:0] !== RFC_Y1) begin
      failures++;
      $display("FAIL rfc_y1 got=%h exp=%h", bus_if.out[511:0], RFC_Y1);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    go_idle();
    bus_if.in = RFC_IN;
    bus_if.init = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_valid got=%b exp=0", bus_if.valid);
    end
    checks++;
    if (bus_if.out !== ZERO) begin
      failures++;
      $display("FAIL midreset_out got=%h exp=0", bus_if.out[1023:896]);
    end
    reset = 1'b0;
    run_to_valid(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL midreset_rerun_latency got=%0d exp=16", lat);
    end
    checks++;
    if (bus_if.out !== RFC_OUT) begin
      failures++;
      $display("FAIL midreset_rerun_out got=%h exp=%h", bus_if.out[1023:896], RFC_OUT[1023:896]);
    end
  endtask

  task automatic test_hold_restart();
    int lat;
    int bad;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.valid !== 1'b1 || bus_if.out !== RFC_OUT) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_stable got=%0d bad_cycles exp=0", bad);
    end
    bus_if.init = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_valid got=%b exp=0", bus_if.valid);
    end
    checks++;
    if (bus_if.out !== RFC_OUT) begin
      failures++;
      $display("FAIL drop_out_held got=%h exp=%h", bus_if.out[1023:896], RFC_OUT[1023:896]);
    end
    bus_if.in = ZERO;
    bus_if.init = 1'b1;
    run_to_valid(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL restart_latency got=%0d exp=16", lat);
    end
    checks++;
    if (bus_if.out !== ZERO) begin
      failures++;
      $display("FAIL restart_out got=%h exp=0", bus_if.out[1023:896]);
    end
  endtask

  // in changes and init drops during SALSA1; result must use the capture
  task automatic test_change_in();
    int lat;
    go_idle();
    bus_if.in = RFC_IN;
    bus_if.init = 1'b1;
    lat = 0;
    @(posedge clk);
    @(negedge clk);
    bus_if.in = ZERO;
    bus_if.init = 1'b0;
    while (lat < LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus_if.valid === 1'b1) break;
    end
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL change_in_latency got=%0d exp=16", lat);
    end
    checks++;
    if (bus_if.out !== RFC_OUT) begin
      failures++;
      $display("FAIL change_in_out got=%h exp=%h", bus_if.out[1023:896], RFC_OUT[1023:896]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL change_in_done_exit got=%b exp=0", bus_if.valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.init = 1'b0;
    bus_if.in = ZERO;
    reset = 1'b1;
    test_reset();
    test_zero();
    test_rfc();
    test_reset_mid();
    test_hold_restart();
    test_change_in();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scrypt_blockmix_r1.md
Name: scrypt_blockmix_r1

Overview:
- Computes scrypt BlockMix (RFC 7914) with r=1 over a 1024-bit block B = B0||B1, using Salsa20/8 as the core hash.
- Sits inside the ROMix pipeline; the ROMix controller pulses or holds init with a block and consumes out when valid rises.
- Iterative: one shared Salsa20/8 datapath, one round per clock, two Salsa invocations per BlockMix.

Parameters:
- ROUNDS, 8, Salsa rounds per invocation; must be even; 8 for scrypt.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  level start request, sampled in IDLE.
- in  in  1024  B0||B1 as a byte string; byte 0 of B0 at in[1023:1016]; in[1023:512]=B0, in[511:0]=B1.
- out  out  1024  Y0||Y1, same byte/word layout as in.
- valid  out  1  result valid, level.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Word format: each 512-bit half holds 16 words; word k occupies bytes 4k..4k+3 and is little-endian. Byte-swap on input and output. All arithmetic is mod 2^32.
- Algorithm:
  - X0 = B1 xor B0; Y0 = Salsa20/8(X0).
  - X1 = Y0 xor B1; Y1 = Salsa20/8(X1).
  - out = Y0||Y1.
- Salsa20/8:
  - 8 rounds, alternating column round (even round index) and row round (odd), standard quarter-round rotations 7, 9, 13, 18.
  - Result = final state + Salsa input, wordwise.
- States: IDLE, SALSA1, SALSA2, DONE. A 3-bit round counter rc is used.
- IDLE:
  - valid=0.
  - If init=1: latch B0 and B1, load state = B1 xor B0, save it as feed-forward F, set rc=0, go to SALSA1.
- SALSA1:
  - Each cycle apply one round and increment rc.
  - On the edge applying round ROUNDS-1: Y0 = roundout + F. Store Y0, load state and F with Y0 xor B1, set rc=0, go to SALSA2.
- SALSA2:
  - Same round schedule.
  - On the last round edge: Y1 = roundout + F. Register out = Y0||Y1, set valid=1, go to DONE.
- DONE:
  - valid=1; out held stable.
  - When init=0, return to IDLE: valid falls and out holds its value.
  - A new start therefore needs init low for at least one cycle.
- Latency: init sampled at edge 0 -> valid=1 after edge 16, i.e. 16 cycles.
- in is ignored after the IDLE capture, so changes to in mid-operation have no effect.
- init deasserted mid-operation: ignored; the computation completes, then the FSM returns to IDLE on the following cycle because init=0 in DONE.
- Reset: in any state forces IDLE and sets valid=0, out=0, rc=0. Reset has priority over init in the same cycle.
- No combinational path from in or init to out or valid.

Decomposition:
- Package scrypt_pkg: typedef word_t (32 bits), block512_t (16 x word_t), ROUNDS, rotation constants 7/9/13/18, and functions quarter_round and bswap32.
- Sub-module salsa_round: combinational; inputs 512-bit state and a col/row select; output is the next state.
- The top module holds the FSM, registers, feed-forward adders and XORs.

Test Plan:
- Reset: hold reset=1 for 5 cycles with init=1 -> valid=0 and out=0 throughout. Release reset, then init=1 -> valid rises exactly 16 cycles later.
- RFC 7914 §9 BlockMix r=1 vector:
  - Input: in = B0 starting f7ce0b653d2d72a4..., B1 starting 894991447213bb22....
  - Required: out[1023:512] = a41f859c6608cc99...c7618f81 (equals the RFC Salsa20/8 output vector).
  - Required: out[511:0] = 20edc975323881a8...4eefe425.
  - Compare all 1024 bits against the RFC.
- All-zero input with init=1 -> out = 0, valid=1 after 16 cycles.
- Reset mid-operation: assert reset at cycle 7 after start -> next cycle valid=0, out=0, state IDLE. Re-run with init -> correct RFC result after 16 cycles.
- Hold and restart:
  - Keep init=1 after valid -> valid stays 1 and out is stable for 20 cycles.
  - Drop init -> valid=0 the next cycle.
  - Raise init with a new in -> new result after 16 cycles.
- Change in during SALSA1 -> result matches the value captured at start.
